// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default widths for the decoder -> sync_fifo -> executer
// sequencer. The address width normally comes from the project-wide
// DECODER_MEM_ADDR_WIDTH macro; a local default keeps this slice buildable
// on its own.
`ifndef DECODER_MEM_ADDR_WIDTH
`define DECODER_MEM_ADDR_WIDTH 12
`endif

package pipe_ctrl_pkg;

  localparam int ADDR_W_DEF = `DECODER_MEM_ADDR_WIDTH;
  localparam int WDOG_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/pipe_wdog.sv
// Saturating inactivity counter. Timeout stays asserted while the count
// sits at its maximum; the owner decides when that matters.
module pipe_wdog #(
  parameter int WDOG_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic timeout
);

  localparam logic [WDOG_W-1:0] CNT_MAX = '1;

  logic [WDOG_W-1:0] cnt;

  // Clear has priority over counting; counting stops at the maximum
  always_ff @(posedge clk) begin
    if (!reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && (cnt != CNT_MAX))
      cnt <= cnt + WDOG_W'(1);
  end

  assign timeout = (cnt == CNT_MAX);

endmodule

// File: rtl/pipe_sequencer.sv
// Top-level controller that walks the decoder through an instruction stream
// block by block, keeps the executer running, waits for the FIFO to drain
// and reports completion, block count and watchdog errors to the host.
// Every output is registered and is a direct decode of the next state.
module pipe_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WDOG_W = WDOG_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              dec_do_it,
  output logic [ADDR_W-1:0] dec_addr,
  input  logic              dec_done,
  input  logic [ADDR_W-1:0] dec_addr_out,
  input  logic              dec_stop,
  output logic              exec_do_it,
  input  logic              exec_done,
  input  logic              exec_stop,
  input  logic              fifo_empty,
  input  logic              fifo_rd,
  output logic              busy,
  output logic              done,
  output logic              wdog_err,
  output logic [CNT_W-1:0]  blk_cnt
);

  state_t            state_q, state_d;
  logic              dec_done_q;
  logic              stop_pend_q, stop_pend_d;
  logic [ADDR_W-1:0] dec_addr_d;
  logic [CNT_W-1:0]  blk_cnt_d;
  logic              wdog_err_d;
  logic              dec_do_it_d, exec_do_it_d, busy_d, done_d;
  logic              done_rise;
  logic              wdog_en, wdog_clr, wdog_timeout, wdog_fire;

  // A level-high dec_done must count exactly once
  assign done_rise = dec_done & ~dec_done_q;

  // Inactivity only matters while waiting on the decoder or the drain
  assign wdog_en   = (state_q == FETCH) || (state_q == DRAIN);
  assign wdog_clr  = done_rise || fifo_rd || (state_d != state_q);
  assign wdog_fire = wdog_timeout && wdog_en && !abort;

  pipe_wdog #(
    .WDOG_W(WDOG_W)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .en     (wdog_en),
    .clr    (wdog_clr),
    .timeout(wdog_timeout)
  );

  // State, data and registered-output flops
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      dec_done_q  <= 1'b0;
      stop_pend_q <= 1'b0;
      dec_addr    <= '0;
      blk_cnt     <= '0;
      wdog_err    <= 1'b0;
      dec_do_it   <= 1'b0;
      exec_do_it  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_done_q  <= dec_done;
      stop_pend_q <= stop_pend_d;
      dec_addr    <= dec_addr_d;
      blk_cnt     <= blk_cnt_d;
      wdog_err    <= wdog_err_d;
      dec_do_it   <= dec_do_it_d;
      exec_do_it  <= exec_do_it_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Next-state selection; abort overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start)
          state_d = FETCH;
      end
      FETCH: begin
        if (wdog_fire)
          state_d = IDLE;
        else if (done_rise)
          state_d = (dec_stop || exec_stop || stop_pend_q) ? DRAIN : GAP;
      end
      GAP: begin
        state_d = exec_stop ? DRAIN : FETCH;
      end
      DRAIN: begin
        if (wdog_fire)
          state_d = IDLE;
        else if (exec_stop || (fifo_empty && exec_done))
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort)
      state_d = IDLE;
  end

  // Next values of the registered outputs and the bookkeeping registers
  always_comb begin
    dec_addr_d   = dec_addr;
    blk_cnt_d    = blk_cnt;
    wdog_err_d   = wdog_err;
    stop_pend_d  = stop_pend_q;
    dec_do_it_d  = (state_d == FETCH);
    exec_do_it_d = (state_d == FETCH) || (state_d == GAP) || (state_d == DRAIN);
    busy_d       = exec_do_it_d;
    done_d       = (state_d == DONE);
    if ((state_q == IDLE) && start && !abort) begin
      dec_addr_d  = start_addr;
      blk_cnt_d   = '0;
      wdog_err_d  = 1'b0;
      stop_pend_d = 1'b0;
    end
    if ((state_q == FETCH) && !abort && !wdog_fire) begin
      if (exec_stop || dec_stop)
        stop_pend_d = 1'b1;
      if (done_rise) begin
        blk_cnt_d  = blk_cnt + CNT_W'(1);
        dec_addr_d = dec_addr_out;
      end
    end
    if (wdog_fire)
      wdog_err_d = 1'b1;
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer. The watchdog is shrunk to 4 bits so a
// timeout happens after 15 idle cycles. Inputs change 1 time unit after a
// rising edge and outputs are sampled at the same point.
module tb_pipe_sequencer;

  localparam int AW = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          dec_do_it;
  logic [AW-1:0] dec_addr;
  logic          dec_done = 1'b0;
  logic [AW-1:0] dec_addr_out = '0;
  logic          dec_stop = 1'b0;
  logic          exec_do_it;
  logic          exec_done = 1'b0;
  logic          exec_stop = 1'b0;
  logic          fifo_empty = 1'b0;
  logic          fifo_rd = 1'b0;
  logic          busy;
  logic          done;
  logic          wdog_err;
  logic [CW-1:0] blk_cnt;

  int checks = 0;
  int failures = 0;

  // Control outputs packed as {dec_do_it, exec_do_it, busy, done}
  logic [3:0] ctl;
  assign ctl = {dec_do_it, exec_do_it, busy, done};

  pipe_sequencer #(
    .ADDR_W(AW),
    .WDOG_W(4),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .start_addr  (start_addr),
    .dec_do_it   (dec_do_it),
    .dec_addr    (dec_addr),
    .dec_done    (dec_done),
    .dec_addr_out(dec_addr_out),
    .dec_stop    (dec_stop),
    .exec_do_it  (exec_do_it),
    .exec_done   (exec_done),
    .exec_stop   (exec_stop),
    .fifo_empty  (fifo_empty),
    .fifo_rd     (fifo_rd),
    .busy        (busy),
    .done        (done),
    .wdog_err    (wdog_err),
    .blk_cnt     (blk_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (ctl !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ctl actual=%b expected=%b", ctl, 4'b0000); end
    checks++; if (wdog_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_wdog actual=%b expected=0", wdog_err); end
    checks++; if (dec_addr !== 12'h000) begin failures++; $display("[TB] FAIL reset_addr actual=%h expected=000", dec_addr); end
    checks++; if (blk_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_blk actual=%0d expected=0", blk_cnt); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_sequence();
    start_addr = 12'h010; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (ctl !== 4'b1110) begin failures++; $display("[TB] FAIL seq_fetch1_ctl actual=%b expected=%b", ctl, 4'b1110); end
    checks++; if (dec_addr !== 12'h010) begin failures++; $display("[TB] FAIL seq_addr1 actual=%h expected=010", dec_addr); end
    tick();
    dec_addr_out = 12'h020; dec_done = 1'b1;
    tick();
    dec_done = 1'b0;
    checks++; if (ctl !== 4'b0110) begin failures++; $display("[TB] FAIL seq_gap1_ctl actual=%b expected=%b", ctl, 4'b0110); end
    checks++; if (dec_addr !== 12'h020) begin failures++; $display("[TB] FAIL seq_addr2 actual=%h expected=020", dec_addr); end
    checks++; if (blk_cnt !== 16'd1) begin failures++; $display("[TB] FAIL seq_blk1 actual=%0d expected=1", blk_cnt); end
    tick();
    checks++; if (ctl !== 4'b1110) begin failures++; $display("[TB] FAIL seq_fetch2_ctl actual=%b expected=%b", ctl, 4'b1110); end
    dec_addr_out = 12'h030; dec_done = 1'b1;
    tick();
    dec_done = 1'b0;
    tick();
    checks++; if (dec_addr !== 12'h030 || dec_do_it !== 1'b1) begin failures++; $display("[TB] FAIL seq_fetch3 actual=%h/%b expected=030/1", dec_addr, dec_do_it); end
    dec_addr_out = 12'h040; dec_done = 1'b1; dec_stop = 1'b1;
    tick();
    dec_done = 1'b0; dec_stop = 1'b0;
    checks++; if (ctl !== 4'b0110) begin failures++; $display("[TB] FAIL seq_drain_ctl actual=%b expected=%b", ctl, 4'b0110); end
    checks++; if (blk_cnt !== 16'd3) begin failures++; $display("[TB] FAIL seq_blk3 actual=%0d expected=3", blk_cnt); end
    tick();
    checks++; if (ctl !== 4'b0110) begin failures++; $display("[TB] FAIL seq_drain_wait actual=%b expected=%b", ctl, 4'b0110); end
    fifo_empty = 1'b1; exec_done = 1'b1;
    tick();
    checks++; if (ctl !== 4'b0001) begin failures++; $display("[TB] FAIL seq_done_ctl actual=%b expected=%b", ctl, 4'b0001); end
    fifo_empty = 1'b0; exec_done = 1'b0;
    tick();
    checks++; if (ctl !== 4'b0000 || blk_cnt !== 16'd3) begin failures++; $display("[TB] FAIL seq_idle actual=%b/%0d expected=0000/3", ctl, blk_cnt); end
  endtask

  task automatic test_exec_stop();
    start_addr = 12'h100; start = 1'b1;
    tick();
    start = 1'b0;
    dec_addr_out = 12'h110; dec_done = 1'b1;
    tick();
    dec_done = 1'b0;
    tick();
    tick();
    exec_stop = 1'b1;
    tick();
    exec_stop = 1'b0;
    checks++; if (ctl !== 4'b1110) begin failures++; $display("[TB] FAIL stop_no_cut actual=%b expected=%b", ctl, 4'b1110); end
    tick();
    fifo_empty = 1'b1; exec_done = 1'b1;
    dec_addr_out = 12'h120; dec_done = 1'b1;
    tick();
    dec_done = 1'b0;
    checks++; if (ctl !== 4'b0110 || blk_cnt !== 16'd2) begin failures++; $display("[TB] FAIL stop_drain actual=%b/%0d expected=0110/2", ctl, blk_cnt); end
    tick();
    checks++; if (ctl !== 4'b0001) begin failures++; $display("[TB] FAIL stop_done actual=%b expected=%b", ctl, 4'b0001); end
    tick();
    checks++; if (ctl !== 4'b0000) begin failures++; $display("[TB] FAIL stop_idle actual=%b expected=%b", ctl, 4'b0000); end
    fifo_empty = 1'b0; exec_done = 1'b0;
  endtask

  task automatic test_done_level();
    start_addr = 12'h200; start = 1'b1;
    tick();
    start = 1'b0;
    dec_addr_out = 12'h210; dec_done = 1'b1;
    repeat (5) tick();
    dec_done = 1'b0;
    checks++; if (blk_cnt !== 16'd1) begin failures++; $display("[TB] FAIL level_blk actual=%0d expected=1", blk_cnt); end
    checks++; if (ctl !== 4'b1110) begin failures++; $display("[TB] FAIL level_fetch actual=%b expected=%b", ctl, 4'b1110); end
    start_addr = 12'h7FF; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (dec_addr !== 12'h210) begin failures++; $display("[TB] FAIL busy_start actual=%h expected=210", dec_addr); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (ctl !== 4'b0000 || blk_cnt !== 16'd1) begin failures++; $display("[TB] FAIL level_abort actual=%b/%0d expected=0000/1", ctl, blk_cnt); end
  endtask

  task automatic test_watchdog();
    start_addr = 12'h300; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    checks++; if (wdog_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL wdog_early actual=%b/%b expected=0/1", wdog_err, busy); end
    tick();
    checks++; if (wdog_err !== 1'b1) begin failures++; $display("[TB] FAIL wdog_err actual=%b expected=1", wdog_err); end
    checks++; if (ctl !== 4'b0000) begin failures++; $display("[TB] FAIL wdog_ctl actual=%b expected=%b", ctl, 4'b0000); end
    tick();
    checks++; if (done !== 1'b0 || wdog_err !== 1'b1) begin failures++; $display("[TB] FAIL wdog_hold actual=%b/%b expected=0/1", done, wdog_err); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (wdog_err !== 1'b0 || ctl !== 4'b1110) begin failures++; $display("[TB] FAIL wdog_clear actual=%b/%b expected=0/1110", wdog_err, ctl); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    start_addr = 12'h400; start = 1'b1;
    tick();
    start = 1'b0;
    dec_addr_out = 12'h410; dec_done = 1'b1; dec_stop = 1'b1;
    tick();
    dec_done = 1'b0; dec_stop = 1'b0;
    checks++; if (ctl !== 4'b0110 || blk_cnt !== 16'd1) begin failures++; $display("[TB] FAIL abort_drain actual=%b/%0d expected=0110/1", ctl, blk_cnt); end
    abort = 1'b1; fifo_empty = 1'b1; exec_done = 1'b1;
    tick();
    checks++; if (ctl !== 4'b0000 || blk_cnt !== 16'd1) begin failures++; $display("[TB] FAIL abort_idle actual=%b/%0d expected=0000/1", ctl, blk_cnt); end
    start_addr = 12'h500; start = 1'b1;
    tick();
    checks++; if (ctl !== 4'b0000 || dec_addr !== 12'h410) begin failures++; $display("[TB] FAIL abort_start actual=%b/%h expected=0000/410", ctl, dec_addr); end
    abort = 1'b0; start = 1'b0; fifo_empty = 1'b0; exec_done = 1'b0;
    tick();
    checks++; if (ctl !== 4'b0000) begin failures++; $display("[TB] FAIL abort_after actual=%b expected=%b", ctl, 4'b0000); end
  endtask

  task automatic test_reset_mid_run();
    start_addr = 12'h600; start = 1'b1;
    tick();
    start = 1'b0;
    dec_addr_out = 12'h610; dec_done = 1'b1;
    tick();
    dec_done = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++; if (ctl !== 4'b0000 || wdog_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_ctl actual=%b/%b expected=0000/0", ctl, wdog_err); end
    checks++; if (dec_addr !== 12'h000 || blk_cnt !== 16'd0) begin failures++; $display("[TB] FAIL rst_mid_data actual=%h/%0d expected=000/0", dec_addr, blk_cnt); end
    reset = 1'b1;
    tick();
    start_addr = 12'h010; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (ctl !== 4'b1110 || dec_addr !== 12'h010) begin failures++; $display("[TB] FAIL rst_restart actual=%b/%h expected=1110/010", ctl, dec_addr); end
    dec_addr_out = 12'h020; dec_done = 1'b1;
    tick();
    dec_done = 1'b0;
    checks++; if (ctl !== 4'b0110 || dec_addr !== 12'h020 || blk_cnt !== 16'd1) begin failures++; $display("[TB] FAIL rst_block1 actual=%b/%h/%0d expected=0110/020/1", ctl, dec_addr, blk_cnt); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Guard against a hung simulation
  initial begin
    #200000;
    $display("[TB] FAIL timeout simulation did not finish");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    test_reset();
    test_sequence();
    test_exec_stop();
    test_done_level();
    test_watchdog();
    test_abort();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
Name: pipe_sequencer

Overview:
- Top-level controller for the decoder -> sync_fifo -> executer instruction stream.
- Sequences the decoder block by block: drives do_it and addr, chains the next address from addr_out, and stops on the decoder or executer stop condition.
- Keeps the executer enabled, waits for the FIFO to drain, and reports completion, block count and watchdog errors to the host.

Parameters:
- ADDR_W, `DECODER_MEM_ADDR_WIDTH, decoder memory address width
- WDOG_W, 16, watchdog counter width; timeout fires at 2**WDOG_W-1 idle cycles
- CNT_W, 16, decoded-block counter width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to run from start_addr; ignored unless IDLE
- abort  in  1  level; forces return to IDLE
- start_addr  in  ADDR_W  first decoder address
- dec_do_it  out  1  decoder enable
- dec_addr  out  ADDR_W  decoder block address
- dec_done  in  1  decoder block-complete (edge-detected internally)
- dec_addr_out  in  ADDR_W  next address reported by decoder
- dec_stop  in  1  decoder hit end of program
- exec_do_it  out  1  executer enable
- exec_done  in  1  executer idle/complete
- exec_stop  in  1  executer executed halt
- fifo_empty  in  1  sync_fifo empty
- fifo_rd  in  1  executer FIFO read strobe (activity only)
- busy  out  1  high in FETCH/GAP/DRAIN
- done  out  1  one-cycle pulse on normal completion
- wdog_err  out  1  sticky timeout flag, cleared by accepted start
- blk_cnt  out  CNT_W  blocks decoded since last start

Behaviour:
- All outputs registered. On reset=0 at a clk edge: state=IDLE; dec_do_it, exec_do_it, busy, done, wdog_err = 0; dec_addr=0; blk_cnt=0. The internal dec_done edge-detect register also clears to 0.
- done_rise = dec_done & ~dec_done_q. A level-high dec_done counts exactly once.
- IDLE: enables low.
  - start=1 -> dec_addr<=start_addr, blk_cnt<=0, wdog_err<=0, wdog<=0 -> FETCH. dec_do_it and exec_do_it go 1 in the cycle after start.
- FETCH: dec_do_it=1, exec_do_it=1.
  - On done_rise: blk_cnt<=blk_cnt+1 (wraps modulo 2**CNT_W), dec_addr<=dec_addr_out, dec_do_it<=0.
  - Then -> DRAIN if dec_stop or exec_stop (same cycle or latched earlier); else -> GAP.
- GAP: exactly one cycle with dec_do_it=0, so the decoder sees a fresh do_it rising edge.
  - -> FETCH, unless exec_stop=1 -> DRAIN.
- DRAIN: dec_do_it=0, exec_do_it=1.
  - exec_stop=1 -> DONE (FIFO contents are discarded by the executer).
  - fifo_empty=1 and exec_done=1 in the same cycle -> DONE.
- DONE: done=1 for one cycle, exec_do_it<=0 -> IDLE.
- exec_stop arriving in FETCH mid-block is latched (stop_pend). The current decoder block completes, then the FSM goes to DRAIN; a block is never cut mid-decode.
- Watchdog:
  - Counts in FETCH and DRAIN; cleared on done_rise, on fifo_rd, and on state entry.
  - Saturating at 2**WDOG_W-1 -> wdog_err<=1, all enables 0, -> IDLE, no done pulse.
- abort=1: highest priority over everything except reset. Next cycle state=IDLE, enables 0, no done pulse; blk_cnt and wdog_err are held.
- start while busy: ignored. start in the same cycle as abort: abort wins, start is dropped.
- Reset mid-run: immediate return to reset values; there is no handshake with decoder or executer.

Decomposition:
- pipe_ctrl_pkg:
  - state enum {IDLE, FETCH, GAP, DRAIN, DONE}
  - WDOG_W/CNT_W defaults
  - ADDR_W derived from `DECODER_MEM_ADDR_WIDTH (`include "common.h")
- Sub-module pipe_wdog: WDOG_W saturating counter with en/clr inputs and a timeout output, instantiated once.

Test Plan:
- start_addr=0x010; decoder returns addr_out 0x020, 0x030, then dec_stop on the third done -> dec_addr sequence 0x010/0x020/0x030, one GAP cycle between blocks, blk_cnt=3, done pulses once after fifo_empty and exec_done.
- exec_stop pulsed mid-FETCH of block 2 -> block 2 completes (blk_cnt=2), no third dec_do_it, DONE within 2 cycles of done_rise.
- dec_done held high 5 cycles -> blk_cnt increments by exactly 1.
- WDOG_W=4, decoder never raises dec_done -> wdog_err=1 after 15 cycles, enables low, no done; a new start clears wdog_err.
- abort asserted in DRAIN, and abort+start in the same IDLE cycle -> IDLE next cycle, no done pulse, start ignored.
- reset=0 asserted in FETCH -> all outputs at reset values on the next edge; the first start after reset behaves as in scenario 1.
